// File: rtl/mem8x8_arbiter_pkg.sv
// mem8x8_arbiter_pkg
//  Shared constants for the mem8x8 two-port arbiter: FSM state encodings and
//  requester IDs. Imported by the RTL and by the testbench.
//  Encoding 2'd3 is unused and recovers to IDLE.
package mem8x8_arbiter_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  localparam logic GNT_A = 1'b0;
  localparam logic GNT_B = 1'b1;

endpackage

// File: rtl/mem_arb_rr_pick.sv
// mem_arb_rr_pick
//  Combinational 2-way picker for the mem8x8 arbiter.
//  Ports:
//    req_a, req_b  in   requests from A and B
//    last_gnt      in   requester granted most recently (round-robin build only)
//    gnt_valid     out  at least one request is present
//    gnt_id        out  requester to grant (GNT_A / GNT_B)
//  Build option: MEM_ARB_FIXED_PRIO_EN selects fixed priority (A always wins a
//  conflict); last_gnt is then not present. Default is round-robin.
module mem_arb_rr_pick
  import mem8x8_arbiter_pkg::*;
(
  input  logic req_a,
  input  logic req_b,
`ifndef MEM_ARB_FIXED_PRIO_EN
  input  logic last_gnt,
`endif
  output logic gnt_valid,
  output logic gnt_id
);

  always_comb begin
    gnt_valid = req_a | req_b;
`ifdef MEM_ARB_FIXED_PRIO_EN
    gnt_id = req_a ? GNT_A : GNT_B;
`else
    // On a conflict, serve whoever was not served last.
    if (req_a && req_b) begin
      gnt_id = (last_gnt == GNT_A) ? GNT_B : GNT_A;
    end else begin
      gnt_id = req_a ? GNT_A : GNT_B;
    end
`endif
  end

endmodule

// File: rtl/mem8x8_arbiter.sv
// mem8x8_arbiter
//  Shares one mem8x8 array between requesters A and B. In IDLE it picks a
//  requester, latches its op/address/data straight into the registered memory
//  pins, holds mem_sel for ACCESS_CYC cycles, captures read data on the edge
//  ending the access, then pulses the requester's ack for one cycle (DONE).
//  Ports:
//    clk, rst                      clock, asynchronous active-high reset
//    req_x, we_x, addr_x, wdata_x  request from A / B (held until ack_x)
//    ack_x, rdata_x                one-cycle completion pulse, read data
//    mem_sel, mem_op, mem_addr,    registered memory control pins
//    mem_din, mem_dout             write data out, read data in
//    busy                          1 whenever the FSM is not in IDLE
//  Build option: MEM_ARB_FIXED_PRIO_EN -> A always wins a conflict and no
//  last-grant state is kept. Default: round-robin.
module mem8x8_arbiter
  import mem8x8_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 3,
  parameter int DATA_W     = 8,
  parameter int ACCESS_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] wdata_a,
  output logic              ack_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic              req_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              ack_b,
  output logic [DATA_W-1:0] rdata_b,
  output logic              mem_sel,
  output logic              mem_op,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy
);

  localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYC - 1);

  logic [1:0]        r_state;
  logic [3:0]        r_cnt;
  logic              r_gnt;
  logic              w_gnt_valid;
  logic              w_gnt_id;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;

`ifndef MEM_ARB_FIXED_PRIO_EN
  logic r_last_gnt;
`endif

  mem_arb_rr_pick u_pick (
    .req_a     (req_a),
    .req_b     (req_b),
`ifndef MEM_ARB_FIXED_PRIO_EN
    .last_gnt  (r_last_gnt),
`endif
    .gnt_valid (w_gnt_valid),
    .gnt_id    (w_gnt_id)
  );

  // Request fields of the requester the picker selects this cycle.
  assign w_we    = (w_gnt_id == GNT_A) ? we_a    : we_b;
  assign w_addr  = (w_gnt_id == GNT_A) ? addr_a  : addr_b;
  assign w_wdata = (w_gnt_id == GNT_A) ? wdata_a : wdata_b;

  assign busy = (r_state != IDLE);

  // The memory pins double as the latched request: mem_op is the latched we,
  // mem_addr the latched address, mem_din the latched write data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= 4'd0;
      r_gnt      <= GNT_A;
`ifndef MEM_ARB_FIXED_PRIO_EN
      r_last_gnt <= GNT_B;
`endif
      ack_a      <= 1'b0;
      ack_b      <= 1'b0;
      rdata_a    <= '0;
      rdata_b    <= '0;
      mem_sel    <= 1'b0;
      mem_op     <= 1'b0;
      mem_addr   <= '0;
      mem_din    <= '0;
    end else begin
      ack_a <= 1'b0;
      ack_b <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_gnt_valid) begin
            r_state    <= ACCESS;
            r_cnt      <= 4'd0;
            r_gnt      <= w_gnt_id;
`ifndef MEM_ARB_FIXED_PRIO_EN
            r_last_gnt <= w_gnt_id;
`endif
            mem_sel    <= 1'b1;
            mem_op     <= w_we;
            mem_addr   <= w_addr;
            mem_din    <= w_we ? w_wdata : '0;
          end
        end
        ACCESS: begin
          if (r_cnt == LAST_CNT) begin
            r_state  <= DONE;
            r_cnt    <= 4'd0;
            mem_sel  <= 1'b0;
            mem_op   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
            // mem_dout is valid in this last access cycle.
            if (r_gnt == GNT_A) begin
              ack_a <= 1'b1;
              if (!mem_op) rdata_a <= mem_dout;
            end else begin
              ack_b <= 1'b1;
              if (!mem_op) rdata_b <= mem_dout;
            end
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state  <= IDLE;
          r_cnt    <= 4'd0;
          mem_sel  <= 1'b0;
          mem_op   <= 1'b0;
          mem_addr <= '0;
          mem_din  <= '0;
        end
      endcase
    end
  end

endmodule
